// File: rtl/rate_counter.sv
// rate_counter: rate-divided up/down modulo counter for seven-segment digits.
// A programmable divider produces a one-cycle tick at one of four rates; the
// counter advances on each tick and pulses wrap on terminal-count rollover.
module rate_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 16,
    parameter int unsigned DIV_W = 28,
    parameter int unsigned RATE0 = 1,
    parameter int unsigned RATE1 = 50_000_000,
    parameter int unsigned RATE2 = 100_000_000,
    parameter int unsigned RATE3 = 200_000_000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       speed,
    input  logic             run,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);

    // Terminal count and divider reload values (period minus one).
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);
    localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(RATE0 - 1);
    localparam logic [DIV_W-1:0] RELOAD1 = DIV_W'(RATE1 - 1);
    localparam logic [DIV_W-1:0] RELOAD2 = DIV_W'(RATE2 - 1);
    localparam logic [DIV_W-1:0] RELOAD3 = DIV_W'(RATE3 - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] reload_c;
    logic [WIDTH-1:0] load_sat_c;

    // Reload value for the selected rate; only consulted when div_q hits zero,
    // so a speed change takes effect at the next reload.
    always_comb begin
        reload_c = RELOAD0;
        case (speed)
            2'b00:   reload_c = RELOAD0;
            2'b01:   reload_c = RELOAD1;
            2'b10:   reload_c = RELOAD2;
            default: reload_c = RELOAD3;
        endcase
    end

    // Loaded value is clamped so count never leaves 0..MOD-1.
    always_comb begin
        load_sat_c = load_val;
        if (load_val > CNT_MAX) begin
            load_sat_c = CNT_MAX;
        end
    end

    // Divider: ticks on the first running edge after reset/clear, then once per period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else if (!run) begin
            tick  <= 1'b0;
        end else if (div_q == '0) begin
            div_q <= reload_c;
            tick  <= 1'b1;
        end else begin
            div_q <= div_q - DIV_W'(1);
            tick  <= 1'b0;
        end
    end

    // Counter: clear, then load, then modulo step on a registered tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_sat_c;
            wrap  <= 1'b0;
        end else if (tick && up) begin
            if (count == CNT_MAX) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
                wrap  <= 1'b0;
            end
        end else if (tick) begin
            if (count == '0) begin
                count <= CNT_MAX;
                wrap  <= 1'b1;
            end else begin
                count <= count - WIDTH'(1);
                wrap  <= 1'b0;
            end
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rate_counter.sv
// tb_rate_counter: directed scoreboard bench for rate_counter
// (MOD=10, WIDTH=4, rates 1/5/10/20).
module tb_rate_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tck;
        logic       wrp;
    } obs_t;

    logic       clock;
    logic       reset_n;
    logic [1:0] speed;
    logic       run;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tick;
    logic       wrap;

    int n_cmp = 0;
    int n_bad = 0;

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  async_q[$];
    string async_name_q[$];
    event  async_ev;

    rate_counter #(
        .WIDTH(4), .MOD(10), .DIV_W(8),
        .RATE0(1), .RATE1(5), .RATE2(10), .RATE3(20)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .speed    (speed),
        .run      (run),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare the current outputs against one scoreboard entry.
    task automatic compare(input string nm, input obs_t e);
        n_cmp++;
        if ({count, tick, wrap} !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got count=%0d tick=%0b wrap=%0b, want count=%0d tick=%0b wrap=%0b",
                     nm, $time, count, tick, wrap, e.cnt, e.tck, e.wrp);
        end
    endtask

    // Clocked monitor: one expectation is consumed just after each checked edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), exp_q.pop_front());
        end
    end

    // Asynchronous monitor: used for checks that must not wait for an edge.
    always @(async_ev) begin
        if (async_q.size() > 0) begin
            compare(async_name_q.pop_front(), async_q.pop_front());
        end
    end

    // Called at a falling edge with inputs applied: expect these outputs after the next rising edge.
    task automatic expect_edge(input string nm, input logic [3:0] c, input logic t, input logic w);
        exp_q.push_back('{cnt: c, tck: t, wrp: w});
        name_q.push_back(nm);
        @(negedge clock);
    endtask

    task automatic expect_now(input string nm, input logic [3:0] c, input logic t, input logic w);
        async_q.push_back('{cnt: c, tck: t, wrp: w});
        async_name_q.push_back(nm);
        -> async_ev;
        #0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; speed = 2'b00; run = 1'b0; up = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 4'd0;
        #1 expect_now("reset_por", 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);

        // Up-count at RATE0: tick every clock, count lags tick by one edge.
        reset_n = 1'b1; speed = 2'b00; up = 1'b1; run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_edge("up_roll", (k == 1) ? 4'd0 : 4'((k - 1) % 10), 1'b1, k == 11);
        end

        // Down-count rollover at RATE1.
        run = 1'b0; load = 1'b1; load_val = 4'd0;
        expect_edge("load0", 4'd0, 1'b0, 1'b0);
        load = 1'b0; up = 1'b0; speed = 2'b01; run = 1'b1;
        expect_edge("dn_first_tick", 4'd0, 1'b1, 1'b0);
        expect_edge("dn_wrap",       4'd9, 1'b0, 1'b1);
        expect_edge("dn_hold",       4'd9, 1'b0, 1'b0);
        expect_edge("dn_hold",       4'd9, 1'b0, 1'b0);
        expect_edge("dn_hold",       4'd9, 1'b0, 1'b0);
        expect_edge("dn_tick2",      4'd9, 1'b1, 1'b0);
        expect_edge("dn_9to8",       4'd8, 1'b0, 1'b0);
        expect_edge("dn_hold8",      4'd8, 1'b0, 1'b0);
        expect_edge("dn_hold8",      4'd8, 1'b0, 1'b0);
        expect_edge("dn_hold8",      4'd8, 1'b0, 1'b0);
        expect_edge("dn_tick3",      4'd8, 1'b1, 1'b0);

        // Load on a tick edge: load wins and saturates to MOD-1.
        load = 1'b1; load_val = 4'd13;
        expect_edge("load_sat", 4'd9, 1'b0, 1'b0);
        load_val = 4'd4;
        expect_edge("load4", 4'd4, 1'b0, 1'b0);
        load = 1'b0;
        expect_edge("pre_freeze", 4'd4, 1'b0, 1'b0);

        // Freeze the divider mid-period for 7 cycles.
        run = 1'b0;
        repeat (7) expect_edge("frozen", 4'd4, 1'b0, 1'b0);
        run = 1'b1;
        expect_edge("resume",      4'd4, 1'b0, 1'b0);
        expect_edge("resume_tick", 4'd4, 1'b1, 1'b0);
        expect_edge("resume_cnt",  4'd3, 1'b0, 1'b0);

        // Speed 01 -> 11 mid-period: current period finishes, then 20-cycle ticks.
        speed = 2'b11; up = 1'b1;
        for (int k = 25; k <= 49; k++) begin
            expect_edge("speed_chg", (k <= 28) ? 4'd3 : ((k <= 48) ? 4'd4 : 4'd5),
                        (k == 28) || (k == 48), 1'b0);
        end

        // Clear with count=6 and divider mid-countdown; then clear on a tick edge.
        load = 1'b1; load_val = 4'd6;
        expect_edge("load6", 4'd6, 1'b0, 1'b0);
        load = 1'b0;
        expect_edge("hold6", 4'd6, 1'b0, 1'b0);
        clr = 1'b1;
        expect_edge("clr", 4'd0, 1'b0, 1'b0);
        clr = 1'b0;
        expect_edge("post_clr_tick", 4'd0, 1'b1, 1'b0);
        clr = 1'b1;
        expect_edge("clr_on_tick", 4'd0, 1'b0, 1'b0);
        clr = 1'b0;
        expect_edge("post_clr_tick2", 4'd0, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd7;
        expect_edge("load_on_tick", 4'd7, 1'b0, 1'b0);
        load = 1'b0;
        expect_edge("hold7", 4'd7, 1'b0, 1'b0);

        // Asynchronous reset between edges, then restart at RATE1.
        #2 reset_n = 1'b0;
        #1 expect_now("reset_async", 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1; speed = 2'b01; up = 1'b1; run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_edge("post_rst", 4'((k + 3) / 5), (k % 5) == 1, 1'b0);
        end

        @(negedge clock);
        if (exp_q.size() != 0 || async_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size() + async_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rate_counter.md
Name: rate_counter

Overview:
- Parametrised, rate-divided modulo counter. Successor to the fixed 4-bit free-running display counter.
- A programmable divider turns the 50 MHz system clock into a one-cycle `tick` at one of four selectable rates.
- An up/down modulo-MOD counter with synchronous load and clear advances on each tick.
- Sits between board switches and the seven-segment decoders; `wrap` allows cascading digits.

Parameters:
- WIDTH, 4: counter width in bits.
- MOD, 16: counter modulus; legal range 2..2^WIDTH. Count runs 0..MOD-1.
- DIV_W, 28: divider register width.
- RATE0, 1: period of `tick` in clocks when `speed`=00.
- RATE1, 50_000_000: period when `speed`=01.
- RATE2, 100_000_000: period when `speed`=10.
- RATE3, 200_000_000: period when `speed`=11.
- Every RATEn must lie in 1..2^DIV_W.

Ports:
- clock  in  1  system clock (CLOCK_50), rising edge.
- reset_n  in  1  asynchronous active-low reset.
- speed  in  2  rate select, indexes RATE0..RATE3.
- run  in  1  1 = divider runs; 0 = divider and counter hold.
- up  in  1  count direction: 1 = up, 0 = down.
- clr  in  1  synchronous clear of divider and counter.
- load  in  1  synchronous parallel load of the counter.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count.
- tick  out  1  registered one-cycle pulse, once per selected period.
- wrap  out  1  registered one-cycle pulse on terminal-count rollover.

Behaviour:
- Reset (async, reset_n=0): div_q=0, count=0, tick=0, wrap=0 immediately. No dependence on `speed` during reset.
- Divider, per rising edge, in priority order:
  - clr=1: div_q<=0, tick<=0.
  - run=0: div_q holds, tick<=0.
  - div_q==0: div_q<=RATE[speed]-1, tick<=1.
  - otherwise: div_q<=div_q-1, tick<=0.
- Divider consequences:
  - First tick after reset or clr is asserted after the first edge with run=1.
  - Thereafter tick is high for exactly 1 of every RATE[speed] cycles.
  - RATE=1 gives tick high continuously while run=1.
- Speed change mid-period: the current countdown completes. The new rate applies from the next reload. No glitch, no extra tick.
- Counter, per rising edge, in priority order:
  - clr=1: count<=0, wrap<=0.
  - load=1: count<=min(load_val, MOD-1), wrap<=0. Load ignores run and tick.
  - tick=1 and up=1:
    - count==MOD-1: count<=0, wrap<=1.
    - otherwise: count<=count+1, wrap<=0.
  - tick=1 and up=0:
    - count==0: count<=MOD-1, wrap<=1.
    - otherwise: count<=count-1, wrap<=0.
  - otherwise: count holds, wrap<=0.
- Latency: count changes on the edge at which tick is sampled high, i.e. one clock after tick rises.
- wrap is high in the same cycle that the wrapped value appears on `count`.
- load or clr on the same edge as tick: load/clr wins, the tick is consumed, and no wrap is produced.
- `up` may change at any time; it is sampled only on tick edges.
- Arithmetic is modulo MOD, never 2^WIDTH (unless MOD=2^WIDTH). No value >= MOD ever appears on `count`.
- Reset asserted mid-period: all state clears asynchronously. After release, behaviour is identical to power-up.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use RATE0..3 = 1, 5, 10, 20 and MOD=10, WIDTH=4.
- Reset: hold reset_n=0 mid-run with count=7 → count=0, tick=0, wrap=0 immediately, without waiting for a clock edge. After release with run=1, speed=01: tick pulses at edges 1, 6, 11, …
- Up-count rollover: speed=00, up=1, run=1 → count 0,1,…,9,0. wrap=1 only in the cycle count returns to 0.
- Down-count rollover: load 0, then up=0, speed=01 → count 0→9 on the first tick with wrap=1, then 9→8 five clocks later with wrap=0.
- Load priority and saturation: load=1 with load_val=13 on a tick edge → count=9, no increment, wrap=0. Then load_val=4 → count=4.
- Run and speed change: run=0 for 7 cycles mid-period → tick and count frozen, and the remaining period resumes on run=1. Switch speed 01→11 mid-period → the current 5-cycle period finishes, then ticks come every 20 cycles.
- Clear: assert clr with count=6, div_q≠0 → count=0 and div_q=0. The next tick appears on the first edge after clr drops.
